// File: rtl/stepper_pkg.sv
// Shared types, phase table and phase-advance helpers for the stepper sequencer.
package stepper_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      JOG  = 2'd1,
      MOVE = 2'd2
   } state_t;

   localparam logic DIR_CW  = 1'b1;
   localparam logic DIR_CCW = 1'b0;

   localparam logic [3:0] PHASE_TABLE [8] = '{
      4'b1010, 4'b1000, 4'b1001, 4'b0001,
      4'b0101, 4'b0100, 4'b0110, 4'b0010
   };

   // Full-step from an odd index moves by one so it realigns onto an even entry.
   function automatic logic [2:0] phase_delta(input logic [2:0] idx, input logic half);
      return (half || idx[0]) ? 3'd1 : 3'd2;
   endfunction

   function automatic logic [2:0] next_phase(input logic [2:0] idx, input logic dir,
                                             input logic half);
      return (dir == DIR_CW) ? idx + phase_delta(idx, half) : idx - phase_delta(idx, half);
   endfunction

endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// Counted-move command channel: host drives the request, sequencer answers with ready.
interface stepper_seq_ctrl_if #(parameter int STEP_W = 16);
   logic              MOVE_VALID;
   logic              MOVE_READY;
   logic              MOVE_DIR;
   logic [STEP_W-1:0] MOVE_STEPS;

   modport master (output MOVE_VALID, MOVE_DIR, MOVE_STEPS, input MOVE_READY);
   modport slave  (input MOVE_VALID, MOVE_DIR, MOVE_STEPS, output MOVE_READY);
endinterface

// File: rtl/stepper_dwell_timer.sv
// Dwell counter: ticks once every max(dwell,1) cycles while run is high.
module stepper_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               clear,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tick
);

   logic [DWELL_W-1:0] count_reg, count_next;
   logic [DWELL_W-1:0] term_last;

   // Compare with >= so a shortened dwell takes effect on the very next cycle.
   always_comb begin
      term_last  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
      tick       = run && !clear && (count_reg >= term_last);
      count_next = count_reg + DWELL_W'(1);
      if (!run || clear || tick) begin
         count_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// 4-coil stepper sequencer with half/full step, programmable dwell, jog and counted moves.
// Define STEPPER_POS_EN to add the signed POSITION tracker with POS_CLR.
module stepper_seq_ctrl
   import stepper_pkg::*;
#(
   parameter int DWELL_W = 16,
   parameter int STEP_W  = 16
`ifdef STEPPER_POS_EN
   ,
   parameter int POS_W   = 24
`endif
) (
   input  logic               SYS_CLK,
   input  logic               FSM_A_RESET_N,
   input  logic               ENABLE,
   input  logic               HALF_STEP,
   input  logic [DWELL_W-1:0] DWELL,
   input  logic               CW,
   input  logic               CCW,
   stepper_seq_ctrl_if.slave  move,
   output logic [3:0]         MOTOR_DRIVE,
   output logic               STEP_PULSE,
   output logic               BUSY,
   output logic               DONE,
   output logic               ABORT,
   output logic [2:0]         PHASE_IDX
`ifdef STEPPER_POS_EN
   ,
   input  logic               POS_CLR,
   output logic signed [POS_W-1:0] POSITION
`endif
);

   state_t            state_reg, state_next;
   logic [2:0]        phase_reg, phase_next;
   logic [3:0]        drive_reg, drive_next;
   logic [STEP_W-1:0] remain_reg, remain_next;
   logic              move_dir_reg, move_dir_next;
   logic              zero_done_reg, zero_done_next;

   logic tmr_run, tmr_clear, tick;
   logic step_dir, ready, busy, done, abort;

   stepper_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .clk   (SYS_CLK),
      .rst_n (FSM_A_RESET_N),
      .run   (tmr_run),
      .clear (tmr_clear),
      .dwell (DWELL),
      .tick  (tick)
   );

   always_comb begin
      state_next     = state_reg;
      phase_next     = phase_reg;
      remain_next    = remain_reg;
      move_dir_next  = move_dir_reg;
      zero_done_next = 1'b0;
      tmr_run        = 1'b0;
      tmr_clear      = 1'b0;
      step_dir       = move_dir_reg;
      ready          = 1'b0;
      busy           = 1'b0;
      done           = zero_done_reg;
      abort          = 1'b0;

      case (state_reg)
         OFF: begin
            if (ENABLE) state_next = JOG;
         end
         JOG: begin
            ready    = ENABLE;
            tmr_run  = ENABLE && (CW != CCW);
            step_dir = CW ? DIR_CW : DIR_CCW;
            if (ENABLE && move.MOVE_VALID) begin
               tmr_clear     = 1'b1;
               move_dir_next = move.MOVE_DIR;
               remain_next   = move.MOVE_STEPS;
               if (move.MOVE_STEPS == '0) zero_done_next = 1'b1;
               else                       state_next     = MOVE;
            end
            if (!ENABLE) state_next = OFF;
         end
         MOVE: begin
            busy    = 1'b1;
            tmr_run = ENABLE;
            if (!ENABLE) begin
               abort       = 1'b1;
               remain_next = '0;
               state_next  = OFF;
            end else if (tick) begin
               remain_next = remain_reg - STEP_W'(1);
               if (remain_reg == STEP_W'(1)) begin
                  done       = 1'b1;
                  state_next = JOG;
               end
            end
         end
         default: state_next = OFF;
      endcase

      if (tick) phase_next = next_phase(phase_reg, step_dir, HALF_STEP);
      drive_next = (state_next == OFF) ? 4'b0000 : PHASE_TABLE[phase_next];
   end

   always_ff @(posedge SYS_CLK or negedge FSM_A_RESET_N) begin
      if (!FSM_A_RESET_N) begin
         state_reg     <= OFF;
         phase_reg     <= '0;
         drive_reg     <= '0;
         remain_reg    <= '0;
         move_dir_reg  <= DIR_CCW;
         zero_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         phase_reg     <= phase_next;
         drive_reg     <= drive_next;
         remain_reg    <= remain_next;
         move_dir_reg  <= move_dir_next;
         zero_done_reg <= zero_done_next;
      end
   end

   assign MOTOR_DRIVE     = drive_reg;
   assign PHASE_IDX       = phase_reg;
   assign STEP_PULSE      = tick;
   assign BUSY            = busy;
   assign DONE            = done;
   assign ABORT           = abort;
   assign move.MOVE_READY = ready;

`ifdef STEPPER_POS_EN
   logic signed [POS_W-1:0] pos_reg, pos_inc;

   always_comb pos_inc = (HALF_STEP || phase_reg[0]) ? POS_W'(1) : POS_W'(2);

   always_ff @(posedge SYS_CLK or negedge FSM_A_RESET_N) begin
      if (!FSM_A_RESET_N) begin
         pos_reg <= '0;
      end else if (POS_CLR) begin
         pos_reg <= '0;
      end else if (tick) begin
         pos_reg <= (step_dir == DIR_CW) ? pos_reg + pos_inc : pos_reg - pos_inc;
      end
   end

   assign POSITION = pos_reg;
`endif

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed self-checking bench for stepper_seq_ctrl (jog, moves, abort, realign, reset).
module tb_stepper_seq_ctrl;

   logic        SYS_CLK = 1'b0;
   logic        FSM_A_RESET_N = 1'b0;
   logic        ENABLE = 1'b0;
   logic        HALF_STEP = 1'b0;
   logic [15:0] DWELL = 16'd0;
   logic        CW = 1'b0;
   logic        CCW = 1'b0;
   logic [3:0]  MOTOR_DRIVE;
   logic        STEP_PULSE, BUSY, DONE, ABORT;
   logic [2:0]  PHASE_IDX;
`ifdef STEPPER_POS_EN
   logic        POS_CLR = 1'b0;
   logic signed [23:0] POSITION;
`endif

   int checks = 0;
   int failures = 0;

   localparam logic [3:0] TBL [8] = '{
      4'b1010, 4'b1000, 4'b1001, 4'b0001,
      4'b0101, 4'b0100, 4'b0110, 4'b0010
   };

   stepper_seq_ctrl_if #(.STEP_W(16)) mif ();

   stepper_seq_ctrl #(.DWELL_W(16), .STEP_W(16)) dut (
      .SYS_CLK       (SYS_CLK),
      .FSM_A_RESET_N (FSM_A_RESET_N),
      .ENABLE        (ENABLE),
      .HALF_STEP     (HALF_STEP),
      .DWELL         (DWELL),
      .CW            (CW),
      .CCW           (CCW),
      .move          (mif),
      .MOTOR_DRIVE   (MOTOR_DRIVE),
      .STEP_PULSE    (STEP_PULSE),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .ABORT         (ABORT),
      .PHASE_IDX     (PHASE_IDX)
`ifdef STEPPER_POS_EN
      ,
      .POS_CLR       (POS_CLR),
      .POSITION      (POSITION)
`endif
   );

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic nxt();
      @(negedge SYS_CLK);
   endtask

   task automatic do_reset();
      FSM_A_RESET_N = 1'b0;
      ENABLE = 1'b0; CW = 1'b0; CCW = 1'b0;
      mif.MOVE_VALID = 1'b0; mif.MOVE_DIR = 1'b0; mif.MOVE_STEPS = 16'd0;
`ifdef STEPPER_POS_EN
      POS_CLR = 1'b0;
`endif
      nxt();
      FSM_A_RESET_N = 1'b1;
   endtask

   // Leaves the bench at the start of the first JOG cycle (dwell counter at 0).
   task automatic go_jog(input logic half, input logic [15:0] dwell);
      HALF_STEP = half; DWELL = dwell; ENABLE = 1'b1;
      nxt();
   endtask

   task automatic test_reset();
      mif.MOVE_VALID = 1'b0; mif.MOVE_DIR = 1'b0; mif.MOVE_STEPS = 16'd0;
      @(posedge SYS_CLK); #1;
      checks++; if (MOTOR_DRIVE !== 4'b0000) begin failures++; $display("FAIL rst_drive: got %b want 0000", MOTOR_DRIVE); end
      checks++; if (PHASE_IDX !== 3'd0) begin failures++; $display("FAIL rst_idx: got %0d want 0", PHASE_IDX); end
      checks++; if ({STEP_PULSE, BUSY, DONE, ABORT, mif.MOVE_READY} !== 5'b0) begin failures++; $display("FAIL rst_flags: got %b want 00000", {STEP_PULSE, BUSY, DONE, ABORT, mif.MOVE_READY}); end
      nxt();
      FSM_A_RESET_N = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_fullstep_cw();
      logic [2:0] ei;
      logic       ep;
      int         pulses = 0;
      do_reset();
      go_jog(1'b0, 16'd4);
      for (int i = 1; i <= 20; i++) begin
         CW = 1'b1; #1;
         ei = 3'((2 * ((i - 1) / 4)) % 8);
         ep = (i % 4 == 0);
         if (STEP_PULSE === 1'b1) pulses++;
         checks++; if (STEP_PULSE !== ep) begin failures++; $display("FAIL fs_pulse c%0d: got %b want %b", i, STEP_PULSE, ep); end
         checks++; if (MOTOR_DRIVE !== TBL[ei]) begin failures++; $display("FAIL fs_drive c%0d: got %b want %b", i, MOTOR_DRIVE, TBL[ei]); end
         nxt();
      end
      CW = 1'b0;
      $display("test_fullstep_cw pulses=%0d", pulses);
   endtask

   task automatic test_halfstep_ccw();
      logic [2:0] ei;
      do_reset();
      go_jog(1'b1, 16'd1);
      for (int i = 1; i <= 4; i++) begin
         CCW = 1'b1; #1;
         ei = 3'((9 - i) % 8);
         checks++; if (STEP_PULSE !== 1'b1) begin failures++; $display("FAIL hs_pulse c%0d: got %b want 1", i, STEP_PULSE); end
         checks++; if (MOTOR_DRIVE !== TBL[ei]) begin failures++; $display("FAIL hs_drive c%0d: got %b want %b", i, MOTOR_DRIVE, TBL[ei]); end
         nxt();
      end
      for (int i = 1; i <= 3; i++) begin
         CW = 1'b1; CCW = 1'b1; #1;
         checks++; if (STEP_PULSE !== 1'b0) begin failures++; $display("FAIL hold_pulse c%0d: got %b want 0", i, STEP_PULSE); end
         checks++; if (MOTOR_DRIVE !== 4'b0101) begin failures++; $display("FAIL hold_drive c%0d: got %b want 0101", i, MOTOR_DRIVE); end
         nxt();
      end
      CW = 1'b0; CCW = 1'b0;
      $display("test_halfstep_ccw done");
   endtask

   task automatic test_move();
      int pulses = 0;
      do_reset();
      go_jog(1'b0, 16'd2);
      mif.MOVE_VALID = 1'b1; mif.MOVE_DIR = 1'b1; mif.MOVE_STEPS = 16'd3; #1;
      checks++; if (mif.MOVE_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL mv_hs: got ready=%b busy=%b want 1 0", mif.MOVE_READY, BUSY); end
      nxt();
      mif.MOVE_VALID = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         #1;
         if (STEP_PULSE === 1'b1) pulses++;
         checks++; if (BUSY !== 1'b1 || mif.MOVE_READY !== 1'b0) begin failures++; $display("FAIL mv_busy c%0d: got busy=%b ready=%b want 1 0", i, BUSY, mif.MOVE_READY); end
         checks++; if (STEP_PULSE !== (i % 2 == 0)) begin failures++; $display("FAIL mv_pulse c%0d: got %b want %b", i, STEP_PULSE, (i % 2 == 0)); end
         checks++; if (DONE !== (i == 6)) begin failures++; $display("FAIL mv_done c%0d: got %b want %b", i, DONE, (i == 6)); end
         nxt();
      end
      #1;
      checks++; if (pulses != 3) begin failures++; $display("FAIL mv_count: got %0d want 3", pulses); end
      checks++; if (mif.MOVE_READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL mv_end: got ready=%b busy=%b done=%b want 1 0 0", mif.MOVE_READY, BUSY, DONE); end
      checks++; if (PHASE_IDX !== 3'd6 || MOTOR_DRIVE !== 4'b0110) begin failures++; $display("FAIL mv_pos: got idx=%0d drive=%b want 6 0110", PHASE_IDX, MOTOR_DRIVE); end
      nxt();
      $display("test_move steps=3 pulses=%0d", pulses);
   endtask

   task automatic test_zero_move();
      do_reset();
      go_jog(1'b0, 16'd2);
      mif.MOVE_VALID = 1'b1; mif.MOVE_DIR = 1'b1; mif.MOVE_STEPS = 16'd0; #1;
      checks++; if (mif.MOVE_READY !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL zm_hs: got ready=%b done=%b busy=%b want 1 0 0", mif.MOVE_READY, DONE, BUSY); end
      nxt();
      mif.MOVE_VALID = 1'b0; #1;
      checks++; if (DONE !== 1'b1 || BUSY !== 1'b0 || STEP_PULSE !== 1'b0) begin failures++; $display("FAIL zm_done: got done=%b busy=%b pulse=%b want 1 0 0", DONE, BUSY, STEP_PULSE); end
      nxt(); #1;
      checks++; if (DONE !== 1'b0 || BUSY !== 1'b0 || mif.MOVE_READY !== 1'b1) begin failures++; $display("FAIL zm_after: got done=%b busy=%b ready=%b want 0 0 1", DONE, BUSY, mif.MOVE_READY); end
      nxt();
      $display("test_zero_move done");
   endtask

   task automatic test_abort();
      do_reset();
      go_jog(1'b0, 16'd1);
      mif.MOVE_VALID = 1'b1; mif.MOVE_DIR = 1'b1; mif.MOVE_STEPS = 16'd10;
      nxt();
      mif.MOVE_VALID = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         checks++; if (STEP_PULSE !== 1'b1) begin failures++; $display("FAIL ab_pulse c%0d: got %b want 1", i, STEP_PULSE); end
         nxt();
      end
      ENABLE = 1'b0; #1;
      checks++; if (ABORT !== 1'b1 || DONE !== 1'b0 || STEP_PULSE !== 1'b0) begin failures++; $display("FAIL ab_cycle: got abort=%b done=%b pulse=%b want 1 0 0", ABORT, DONE, STEP_PULSE); end
      nxt(); #1;
      checks++; if (MOTOR_DRIVE !== 4'b0000 || PHASE_IDX !== 3'd4) begin failures++; $display("FAIL ab_off: got drive=%b idx=%0d want 0000 4", MOTOR_DRIVE, PHASE_IDX); end
      checks++; if (ABORT !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL ab_flags: got abort=%b done=%b busy=%b want 0 0 0", ABORT, DONE, BUSY); end
      ENABLE = 1'b1;
      nxt(); #1;
      checks++; if (MOTOR_DRIVE !== 4'b0101 || mif.MOVE_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL ab_resume: got drive=%b ready=%b busy=%b want 0101 1 0", MOTOR_DRIVE, mif.MOVE_READY, BUSY); end
      nxt();
      $display("test_abort done");
   endtask

   task automatic test_realign();
      do_reset();
      go_jog(1'b1, 16'd1);
      CW = 1'b1; #1;
      checks++; if (STEP_PULSE !== 1'b1 || PHASE_IDX !== 3'd0) begin failures++; $display("FAIL ra_c1: got pulse=%b idx=%0d want 1 0", STEP_PULSE, PHASE_IDX); end
      nxt();
      HALF_STEP = 1'b0; #1;
      checks++; if (PHASE_IDX !== 3'd1 || MOTOR_DRIVE !== 4'b1000) begin failures++; $display("FAIL ra_c2: got idx=%0d drive=%b want 1 1000", PHASE_IDX, MOTOR_DRIVE); end
`ifdef STEPPER_POS_EN
      checks++; if (POSITION !== 24'sd1) begin failures++; $display("FAIL ra_pos1: got %0d want 1", POSITION); end
`endif
      nxt(); #1;
      checks++; if (PHASE_IDX !== 3'd2 || MOTOR_DRIVE !== 4'b1001) begin failures++; $display("FAIL ra_c3: got idx=%0d drive=%b want 2 1001", PHASE_IDX, MOTOR_DRIVE); end
`ifdef STEPPER_POS_EN
      checks++; if (POSITION !== 24'sd2) begin failures++; $display("FAIL ra_pos2: got %0d want 2", POSITION); end
`endif
      nxt();
`ifdef STEPPER_POS_EN
      POS_CLR = 1'b1;
`endif
      #1;
      checks++; if (PHASE_IDX !== 3'd4 || MOTOR_DRIVE !== 4'b0101) begin failures++; $display("FAIL ra_c4: got idx=%0d drive=%b want 4 0101", PHASE_IDX, MOTOR_DRIVE); end
`ifdef STEPPER_POS_EN
      checks++; if (POSITION !== 24'sd4) begin failures++; $display("FAIL ra_pos4: got %0d want 4", POSITION); end
`endif
      nxt();
      CW = 1'b0;
`ifdef STEPPER_POS_EN
      POS_CLR = 1'b0;
`endif
      #1;
      checks++; if (PHASE_IDX !== 3'd6) begin failures++; $display("FAIL ra_c5: got idx=%0d want 6", PHASE_IDX); end
`ifdef STEPPER_POS_EN
      checks++; if (POSITION !== 24'sd0) begin failures++; $display("FAIL ra_posclr: got %0d want 0", POSITION); end
`endif
      nxt();
      $display("test_realign done");
   endtask

   task automatic test_dwell_change();
      do_reset();
      go_jog(1'b1, 16'd8);
      for (int i = 1; i <= 4; i++) begin
         CW = 1'b1; #1;
         checks++; if (STEP_PULSE !== 1'b0) begin failures++; $display("FAIL dw_wait c%0d: got %b want 0", i, STEP_PULSE); end
         nxt();
      end
      DWELL = 16'd3; #1;
      checks++; if (STEP_PULSE !== 1'b1) begin failures++; $display("FAIL dw_shrink: got %b want 1", STEP_PULSE); end
      nxt();
      DWELL = 16'd0; #1;
      checks++; if (STEP_PULSE !== 1'b1) begin failures++; $display("FAIL dw_zero_a: got %b want 1", STEP_PULSE); end
      nxt(); #1;
      checks++; if (STEP_PULSE !== 1'b1) begin failures++; $display("FAIL dw_zero_b: got %b want 1", STEP_PULSE); end
      nxt();
      CW = 1'b0; #1;
      checks++; if (PHASE_IDX !== 3'd3 || STEP_PULSE !== 1'b0) begin failures++; $display("FAIL dw_end: got idx=%0d pulse=%b want 3 0", PHASE_IDX, STEP_PULSE); end
      nxt();
      $display("test_dwell_change done");
   endtask

   task automatic test_midmove_reset();
      do_reset();
      go_jog(1'b0, 16'd1);
      mif.MOVE_VALID = 1'b1; mif.MOVE_DIR = 1'b0; mif.MOVE_STEPS = 16'd5;
      nxt();
      mif.MOVE_VALID = 1'b0;
      nxt(); nxt(); #1;
      checks++; if (PHASE_IDX !== 3'd4 || BUSY !== 1'b1) begin failures++; $display("FAIL mr_pre: got idx=%0d busy=%b want 4 1", PHASE_IDX, BUSY); end
      FSM_A_RESET_N = 1'b0; #1;
      checks++; if (MOTOR_DRIVE !== 4'b0000 || PHASE_IDX !== 3'd0) begin failures++; $display("FAIL mr_regs: got drive=%b idx=%0d want 0000 0", MOTOR_DRIVE, PHASE_IDX); end
      checks++; if ({STEP_PULSE, BUSY, DONE, ABORT, mif.MOVE_READY} !== 5'b0) begin failures++; $display("FAIL mr_flags: got %b want 00000", {STEP_PULSE, BUSY, DONE, ABORT, mif.MOVE_READY}); end
      nxt();
      FSM_A_RESET_N = 1'b1;
      $display("test_midmove_reset done");
   endtask

   initial begin
      test_reset();
      test_fullstep_cw();
      test_halfstep_ccw();
      test_move();
      test_zero_move();
      test_abort();
      test_realign();
      test_dwell_change();
      test_midmove_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stepper_seq_ctrl.md
Name: stepper_seq_ctrl

Overview:
- Parametrised successor to the 4-coil full-step motor FSM.
- Adds half-step mode and a programmable dwell period in place of the fixed count-to-8.
- Adds a counted-move command with a valid/ready handshake, alongside the existing CW/CCW jog inputs.
- Sits between the host control registers and the coil driver pins; drives MOTOR_DRIVE directly.

Parameters:
- DWELL_W, 16, width of the dwell (cycles-per-step) input.
- STEP_W, 16, width of the move step count.
- POS_W, 24, width of the signed position register (used only with STEPPER_POS_EN).

Ports:
- SYS_CLK  in  1  system clock, all logic on rising edge.
- FSM_A_RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  coil enable; 0 de-energises the coils and aborts any move.
- HALF_STEP  in  1  1 = 8-phase half-step; 0 = 4-phase full-step.
- DWELL  in  DWELL_W  cycles per step; 0 is treated as 1.
- CW, CCW  in  1  jog direction levels; honoured only when no move is active.
- MOVE_VALID  in  1  move request.
- MOVE_READY  out  1  move can be accepted.
- MOVE_DIR  in  1  move direction, 1 = CW.
- MOVE_STEPS  in  STEP_W  number of steps in the move.
- MOTOR_DRIVE  out  4  registered coil pattern.
- STEP_PULSE  out  1  one-cycle pulse on every phase advance.
- BUSY  out  1  move in progress.
- DONE  out  1  one-cycle pulse when a move completes.
- ABORT  out  1  one-cycle pulse when a move is cancelled by ENABLE=0.
- PHASE_IDX  out  3  current phase-table index.

Behaviour:
- Reset values: MOTOR_DRIVE=0000, PHASE_IDX=0, dwell counter=0, remaining-step counter=0, state=OFF; STEP_PULSE, BUSY, DONE, ABORT, MOVE_READY all 0.
- Phase table, index 0..7: 1010, 1000, 1001, 0001, 0101, 0100, 0110, 0010. Full-step uses the even entries only (1010, 1001, 0101, 0110).
- CW adds to the index and CCW subtracts, modulo 8. The step size is 1 in half-step mode and 2 in full-step mode.
- Full-step from an odd index: the next step moves ±1, landing on the even entry in the step direction (realignment).
- MOTOR_DRIVE is registered: it equals table[PHASE_IDX] in JOG/MOVE and 0000 in OFF. PHASE_IDX is retained through OFF.
- State OFF (ENABLE=0):
  - coils off, dwell counter held at 0.
  - ENABLE=1 → JOG on the next cycle.
- State JOG:
  - MOVE_READY=1.
  - CW==CCW: no stepping; dwell counter held at 0.
  - CW!=CCW: the counter counts 0..max(DWELL,1)-1. At terminal count it wraps to 0, the index advances and STEP_PULSE=1 in that cycle.
  - A new DWELL value takes effect on the next compare. If the counter is already at or above the new terminal count, it steps immediately.
  - MOVE_VALID & MOVE_READY: latch MOVE_DIR and MOVE_STEPS, clear the dwell counter; next state is MOVE, or stays JOG with DONE=1 in the following cycle if MOVE_STEPS=0.
- State MOVE:
  - BUSY=1, MOVE_READY=0; CW/CCW ignored.
  - Steps at the dwell rate in the latched direction and decrements remaining steps on each STEP_PULSE.
  - The cycle that issues the last step also asserts DONE and moves to JOG.
- Latency: first step of a move occurs max(DWELL,1) cycles after the handshake cycle. Steady rate is one step per max(DWELL,1) cycles. DWELL=1 gives a step every cycle.
- ENABLE=0 in any state → OFF on the next edge. If a move was in progress: ABORT=1 for one cycle, remaining steps cleared, DONE not asserted.
- HALF_STEP change mid-move: takes effect at the next step; the remaining step count is unchanged.
- Async reset mid-operation returns all registers to their reset values immediately, with no DONE or ABORT.

Optional Feature:
- Macro STEPPER_POS_EN.
- Defined:
  - Adds output POSITION [POS_W-1:0], signed, reset 0.
  - Each STEP_PULSE adds +1 (CW) or -1 (CCW) in half-step units. In full-step mode the increment is ±2, or ±1 on a realigning step.
  - Wraps two's-complement.
  - Adds input POS_CLR (synchronous clear). POS_CLR has priority over a simultaneous step.
- Undefined: neither port exists and there is no position logic.

Decomposition:
- Package stepper_pkg holds:
  - the phase-table constant array (8×4 bits);
  - the state enum {OFF, JOG, MOVE};
  - direction constants DIR_CW=1, DIR_CCW=0.
- Sub-module stepper_dwell_timer (DWELL_W): inputs run, clear and dwell; output tick at terminal count; implements the DWELL=0→1 rule.

Test Plan:
- Reset, then ENABLE=1, HALF_STEP=0, DWELL=4, CW=1 for 20 cycles → STEP_PULSE every 4 cycles; MOTOR_DRIVE 1010→1001→0101→0110→1010.
- HALF_STEP=1, DWELL=1, CCW=1 from index 0 → one step per cycle; MOTOR_DRIVE 1010→0010→0110→0100…; CW=CCW=1 → holds the pattern, no pulses.
- Move handshake with MOVE_STEPS=3, MOVE_DIR=1, DWELL=2 → MOVE_READY=0 and BUSY=1; exactly 3 STEP_PULSEs; DONE coincides with the 3rd pulse; then back to JOG with MOVE_READY=1.
- MOVE_STEPS=0 → no STEP_PULSE; DONE one cycle after the handshake; BUSY never asserted.
- ENABLE=0 after 2 of 10 move steps → ABORT pulse, no DONE, MOTOR_DRIVE=0000; re-enable → drive resumes at the retained PHASE_IDX.
- Half-step to index 1, then switch to full-step CW → next index 2 (1001), then 4 (0101); with STEPPER_POS_EN, POSITION goes 1, 2, 4.
